// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg: opcode constants, instruction field positions and a register-write helper
package instr_decode_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    function automatic logic op_writes(input logic [5:0] op);
        return !(op == OP_SW || op == OP_BEQ || op == OP_BNE);
    endfunction
endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: 32-bit pending-write tracker; set wins over clear, register 0 never pending
module decode_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_sel,
    input  logic        clr_en,
    input  logic [4:0]  clr_sel,
    output logic [31:0] pending
);
    logic [31:0] set_mask, clr_mask;
    always_comb begin
        set_mask = set_en ? (32'd1 << set_sel) : '0;
        clr_mask = clr_en ? (32'd1 << clr_sel) : '0;
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) pending <= '0;
        else      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
endmodule

// File: rtl/instr_decode.sv
// instr_decode: MIPS decode stage with one-deep output register and optional RAW hazard stall.
// Define HAZARD_SCOREBOARD_EN to enable the pending-write scoreboard; otherwise stall is tied low.
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [4:0]  sel_o1,
    output logic [4:0]  sel_o2,
    output logic        RD,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_sel,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_dest,
    output logic        ex_wr
);
    logic [5:0] op;
    logic [4:0] rs, rt, rd, dest;
    logic       wr, stall, accept;

    assign op     = instr[OP_HI:OP_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign dest   = (op == OP_RTYPE) ? rd : rt;
    assign wr     = op_writes(op) && dest != 5'd0;
    assign sel_o1 = rs;
    assign sel_o2 = rt;
    assign RD     = EN && instr_valid;

`ifdef HAZARD_SCOREBOARD_EN
    logic [31:0] pending;
    decode_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (accept && wr),
        .set_sel (dest),
        .clr_en  (wb_valid),
        .clr_sel (wb_sel),
        .pending (pending)
    );
    assign stall = pending[rs] || pending[rt];
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_sel};
    assign stall     = 1'b0;
`endif

    assign instr_ready = EN && !stall && (!ex_valid || ex_ready);
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_wr     <= 1'b0;
            ex_opcode <= '0;
            ex_funct  <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
            ex_dest   <= '0;
        end else if (EN) begin
            if (accept) begin
                ex_valid  <= 1'b1;
                ex_wr     <= wr;
                ex_opcode <= op;
                ex_funct  <= instr[FN_HI:FN_LO];
                ex_a      <= Op1;
                ex_b      <= Op2;
                ex_imm    <= {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
                ex_dest   <= dest;
            end else if (ex_ready) begin
                ex_valid  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: randomized + directed bench; a model queue holds expected bundles, a negedge monitor checks them
module tb_instr_decode;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        EN = 1'b0, instr_valid = 1'b0, ex_ready = 1'b0, wb_valid = 1'b0;
    logic [31:0] instr = '0, Op1 = '0, Op2 = '0;
    logic [4:0]  wb_sel = '0;
    logic        instr_ready, RD, ex_valid, ex_wr;
    logic [4:0]  sel_o1, sel_o2, ex_dest;
    logic [5:0]  ex_opcode, ex_funct;
    logic [31:0] ex_a, ex_b, ex_imm;

    typedef struct {
        logic [5:0]  op, fn;
        logic [31:0] a, b, imm;
        logic [4:0]  dest;
        logic        wr;
    } bundle_t;

    bundle_t q[$];
    bundle_t stg;
    bit      stg_v = 0;
    bit      pend[32];
    int      n_cmp = 0, n_fail = 0;

    instr_decode dut (
        .clk(clk), .rst(rst), .EN(EN), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .sel_o1(sel_o1), .sel_o2(sel_o2), .RD(RD),
        .Op1(Op1), .Op2(Op2), .wb_valid(wb_valid), .wb_sel(wb_sel),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_wr(ex_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    // Drive one cycle of inputs just after the edge; model outcome becomes visible after the following edge.
    task automatic step(input logic r, input logic en, input logic iv, input logic [31:0] ins,
                        input logic er, input logic wv, input logic [4:0] ws,
                        input logic [31:0] a, input logic [31:0] b);
        bundle_t bd;
        logic    exp_rdy;
        @(posedge clk);
        if (stg_v) q.push_back(stg);
        stg_v = 0;
        #1;
        rst = r; EN = en; instr_valid = iv; instr = ins; ex_ready = er;
        wb_valid = wv; wb_sel = ws; Op1 = a; Op2 = b;
        #1;
        if (!rst) begin
            q.delete();
            foreach (pend[i]) pend[i] = 0;
        end else begin
            exp_rdy = en && !(pend[ins[25:21]] || pend[ins[20:16]]) && (q.size() == 0 || er);
            check("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
            check("rd_en", {31'd0, RD}, {31'd0, en && iv});
            check("sel_o1", {27'd0, sel_o1}, {27'd0, ins[25:21]});
            check("sel_o2", {27'd0, sel_o2}, {27'd0, ins[20:16]});
`ifdef HAZARD_SCOREBOARD_EN
            if (wv && ws != 0) pend[ws] = 0;
`endif
            if (iv && exp_rdy) begin
                bd.op   = ins[31:26];
                bd.fn   = ins[5:0];
                bd.a    = a;
                bd.b    = b;
                bd.imm  = {{16{ins[15]}}, ins[15:0]};
                bd.dest = (bd.op == 6'h00) ? ins[15:11] : ins[20:16];
                bd.wr   = !(bd.op inside {6'h2B, 6'h04, 6'h05}) && bd.dest != 0;
                stg     = bd;
                stg_v   = 1;
`ifdef HAZARD_SCOREBOARD_EN
                if (bd.wr) pend[bd.dest] = 1;
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
            check("rst_ex_wr", {31'd0, ex_wr}, 32'd0);
            check("rst_ex_fields", ex_a | ex_b | ex_imm | {15'd0, ex_opcode, ex_funct, ex_dest}, 32'd0);
        end else begin
            check("ex_valid", {31'd0, ex_valid}, {31'd0, q.size() != 0});
            if (q.size() != 0) begin
                check("ex_opcode", {26'd0, ex_opcode}, {26'd0, q[0].op});
                check("ex_funct", {26'd0, ex_funct}, {26'd0, q[0].fn});
                check("ex_a", ex_a, q[0].a);
                check("ex_b", ex_b, q[0].b);
                check("ex_imm", ex_imm, q[0].imm);
                check("ex_dest", {27'd0, ex_dest}, {27'd0, q[0].dest});
                check("ex_wr", {31'd0, ex_wr}, {31'd0, q[0].wr});
                if (EN && ex_ready) void'(q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        int op;
        case ($urandom_range(0, 6))
            0, 1:    op = 6'h00;
            2:       op = 6'h08;
            3:       op = 6'h2B;
            4:       op = 6'h04;
            5:       op = 6'h05;
            default: op = $urandom_range(0, 63);
        endcase
        return op == 0 ? r_type($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63))
                       : i_type(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
    endfunction

    initial begin
        // reset held with a valid instruction offered, then first accept on release
        repeat (3) step(0, 1, 1, 32'h00851020, 1, 0, 0, 32'd3, 32'd4);
        step(1, 1, 1, 32'h00851020, 1, 0, 0, 32'd3, 32'd4);
        // I-type with negative immediate, then a store
        step(1, 1, 1, i_type(8, 0, 10, 16'hFFF9), 1, 0, 0, $urandom, $urandom);
        step(1, 1, 1, i_type(6'h2B, 1, 3, 4), 1, 0, 0, $urandom, $urandom);
        // RAW on r2 until writeback clears it
        step(1, 1, 1, i_type(8, 2, 7, 1), 1, 0, 0, 32'd11, 32'd12);
        step(1, 1, 1, i_type(8, 2, 7, 1), 1, 0, 0, 32'd11, 32'd12);
        step(1, 1, 1, i_type(8, 2, 7, 1), 1, 1, 5'd2, 32'd11, 32'd12);
        step(1, 1, 1, i_type(8, 2, 7, 1), 1, 0, 0, 32'd11, 32'd12);
        // backpressure: hold for 3 cycles, then release with a new instruction
        step(1, 1, 1, i_type(8, 1, 11, 5), 0, 0, 0, 32'd21, 32'd22);
        repeat (3) step(1, 1, 1, i_type(8, 1, 12, 6), 0, 0, 0, 32'd23, 32'd24);
        step(1, 1, 1, i_type(8, 1, 12, 6), 1, 0, 0, 32'd23, 32'd24);
        step(1, 1, 1, i_type(8, 1, 13, 7), 1, 0, 0, 32'd25, 32'd26);
        // set and clear of r6 in the same cycle, then a reader of r6
        step(1, 1, 1, i_type(8, 1, 6, 9), 1, 1, 5'd6, 32'd31, 32'd32);
        step(1, 1, 1, r_type(6, 1, 9, 6'h20), 1, 0, 0, 32'd33, 32'd34);
        step(1, 1, 1, r_type(6, 1, 9, 6'h20), 1, 1, 5'd6, 32'd33, 32'd34);
        step(1, 1, 1, r_type(6, 1, 9, 6'h20), 0, 0, 0, 32'd33, 32'd34);
        // stage disabled for 2 cycles: state frozen while writeback clears still apply
        repeat (2) step(1, 0, 1, i_type(8, 1, 14, 3), 1, 1, 5'd9, $urandom, $urandom);
        step(1, 1, 1, i_type(8, 9, 14, 3), 1, 0, 0, 32'd41, 32'd42);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 7)), $urandom, $urandom);
        for (int r = 0; r < 32; r++) step(1, 1, 0, '0, 1, 1, r[4:0], '0, '0);
        repeat (3) step(1, 1, 0, '0, 1, 0, 0, '0, '0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have one clock, clk, and one asynchronous active-low reset, rst. Both ports are listed below.
REQ-002 SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- EN  in  1  stage enable; low freezes all state
- instr_valid  in  1  fetch offers instr
- instr  in  32  MIPS-format instruction word
- instr_ready  out  1  decode accepts instr this cycle
- sel_o1 / sel_o2  out  5 each  register-file read selects (rs / rt)
- RD  out  1  register-file read enable
- Op1 / Op2  in  32 each  register-file read data, combinational from sel_o1 / sel_o2
- wb_valid  in  1  writeback retiring a register write
- wb_sel  in  5  register written by writeback
- ex_valid  out  1  decoded bundle valid
- ex_ready  in  1  execute consumes the bundle
- ex_opcode / ex_funct  out  6 each  instr[31:26] / instr[5:0]
- ex_a / ex_b  out  32 each  operands (Op1 / Op2 captured)
- ex_imm  out  32  sign-extended instr[15:0]
- ex_dest  out  5  destination register
- ex_wr  out  1  bundle writes ex_dest

Function
REQ-003 SHALL decode instruction fields as follows: rs=instr[25:21], rt=instr[20:16], rd=instr[15:11].
REQ-004 SHALL drive sel_o1=rs and sel_o2=rt combinationally, and SHALL assert RD whenever EN=1 and instr_valid=1.
REQ-005 SHALL set the destination by opcode: R-type (opcode 0x00) uses ex_dest=rd, and all other opcodes use ex_dest=rt.
REQ-006 SHALL set ex_wr=0 for opcodes 0x2B (sw), 0x04 (beq) and 0x05 (bne), and for any bundle whose destination is register 0; ex_wr SHALL be 1 otherwise.
REQ-007 SHALL compute stall = rs pending OR rt pending (register 0 is never pending).
REQ-008 SHALL compute instr_ready = EN AND NOT stall AND (NOT ex_valid OR ex_ready).
REQ-009 SHALL accept an instruction when instr_valid AND instr_ready. On accept, all ex_* outputs SHALL be registered at the next edge, with one cycle of latency.
REQ-010 SHALL hold all ex_* outputs stable while ex_valid=1 and ex_ready=0.
REQ-011 SHALL clear ex_valid when ex_ready=1 and no new instruction is accepted in the same cycle. Accept and consume in the same cycle SHALL give back-to-back throughput.
REQ-012 SHALL maintain a 32-bit pending scoreboard: the bit for ex_dest is set on accept when ex_wr=1, and the bit for wb_sel is cleared when wb_valid=1.
REQ-013 SHALL evaluate stall against the registered scoreboard. A wb_valid clear SHALL therefore release a stalled instruction one cycle later.
REQ-014 SHALL let set win when a set and a clear target the same register in the same cycle.
REQ-015 SHALL ignore wb_valid with wb_sel=0, and SHALL ignore a clear of a bit that is not pending.
REQ-016 SHALL, while EN=0, hold all registers, drive instr_ready=0 and RD=0, and still apply scoreboard clears from wb_valid.

Reset
REQ-017 SHALL, while rst=0, force the following values asynchronously: ex_valid=0, ex_wr=0, ex_opcode, ex_funct, ex_a, ex_b, ex_imm and ex_dest all 0, and the scoreboard all 0.
REQ-018 SHALL discard any in-flight bundle and all pending bits on a reset asserted mid-operation. The first accept SHALL occur no earlier than the first edge after rst returns high.

Configuration
REQ-019 SHALL use the macro HAZARD_SCOREBOARD_EN to select hazard tracking. When defined, the scoreboard and stall behave as specified above.
REQ-020 SHALL, when HAZARD_SCOREBOARD_EN is undefined, omit the scoreboard, tie stall to 0 and ignore wb_valid/wb_sel. All other behaviour SHALL be unchanged.

Structure
REQ-021 SHALL place the following in a shared package: the opcode constants (R-type 0x00, sw 0x2B, beq 0x04, bne 0x05) and the field bit positions.
REQ-022 SHALL implement the scoreboard as one sub-module, decode_scoreboard, with set/clear inputs and a 32-bit pending output.

Verification
REQ-023 SHALL cover reset: hold rst=0 with instr_valid=1, then release -> ex_valid=0 and ex_* all 0 during reset, and the first accept occurs on the edge after release.
REQ-024 SHALL cover an R-type instruction: instr=0x00851020 (add rd=2, rs=4, rt=5), with Op1=3 and Op2=4 -> next cycle ex_dest=2, ex_wr=1, ex_a=3, ex_b=4, and pending[2]=1.
REQ-025 SHALL cover an I-type instruction: addi rt=10, rs=0, imm=0xFFF9 -> ex_dest=10, ex_imm=0xFFFFFFF9, ex_wr=1. A sw instruction -> ex_wr=0 and no pending bit set.
REQ-026 SHALL cover a RAW hazard: issue a write to r2, then present an instruction reading r2 -> instr_ready=0. Pulse wb_valid with wb_sel=2 -> instr_ready=1 one cycle after the clear.
REQ-027 SHALL cover backpressure: ex_ready=0 for 3 cycles -> ex_* stable and instr_ready=0. Then ex_ready=1 with a new instr -> a new bundle appears the next cycle with no bubble.
REQ-028 SHALL cover the simultaneous case: accept a write to r6 while wb_valid=1, wb_sel=6 -> pending[6]=1 afterwards. Also cover EN=0 for 2 cycles -> outputs frozen.
